// File: rtl/hc595_serializer.sv
// Serialises {sel,seg} as a 14-bit frame into a 74HC595 chain and latches it once per frame.
// Latency: inputs sampled at frame start reach the 595 outputs at that frame's stcp (14*DIV cycles).
// Backpressure: none; frames are re-sent back to back, frame_done paces upstream.
module hc595_serializer #(
    parameter int DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       frame_done
);

    localparam logic [3:0] P_LAST = 4'(DIV - 1);
    localparam logic [3:0] P_HALF = 4'(DIV / 2);
    localparam logic [3:0] B_LAST = 4'd13;

    logic [3:0]  p_q, p_d;
    logic [3:0]  b_q, b_d;
    logic [13:0] snap_q, snap_d;
    logic        ds_q, ds_d;
    logic        shcp_q, shcp_d;
    logic        stcp_q, stcp_d;
    logic        oe_q, oe_d;
    logic [13:0] w_live;

    // Snapshot holds the frame already in transmit order: bit k is shifted out k-th.
    always_comb begin
        w_live = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6], seg[7], sel};
    end

    always_comb begin
        p_d    = (p_q == P_LAST) ? 4'd0 : p_q + 4'd1;
        b_d    = b_q;
        snap_d = snap_q;
        ds_d   = ds_q;
        shcp_d = shcp_q;
        stcp_d = 1'b0;
        oe_d   = 1'b0;

        if (p_q == P_LAST) begin
            b_d = (b_q == B_LAST) ? 4'd0 : b_q + 4'd1;
        end

        // Bit 0 goes out from the live inputs on the same edge the snapshot is taken.
        if (p_q == 4'd0) begin
            if (b_q == 4'd0) begin
                snap_d = w_live;
                ds_d   = w_live[0];
            end else begin
                ds_d   = snap_q[b_q];
            end
        end

        if (p_q == P_HALF) begin
            shcp_d = 1'b1;
        end else if (p_q == 4'd0) begin
            shcp_d = 1'b0;
        end

        if ((b_q == B_LAST) && (p_q == P_LAST)) begin
            stcp_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_q    <= 4'd0;
            b_q    <= 4'd0;
            snap_q <= 14'd0;
            ds_q   <= 1'b0;
            shcp_q <= 1'b0;
            stcp_q <= 1'b0;
            oe_q   <= 1'b1;
        end else begin
            p_q    <= p_d;
            b_q    <= b_d;
            snap_q <= snap_d;
            ds_q   <= ds_d;
            shcp_q <= shcp_d;
            stcp_q <= stcp_d;
            oe_q   <= oe_d;
        end
    end

    assign ds         = ds_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign frame_done = stcp_q;
    assign oe         = oe_q;

endmodule
